// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encoding and nibble width for the serial adder
package nibble_serial_adder_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/nibble_serial_adder_cla.sv
// four_bit_cla: 4-bit carry-lookahead adder slice
module four_bit_cla (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    assign g = A & B;
    assign p = A ^ B;
    assign c[0] = C0;
    assign c[1] = g[0] | (p[0] & C0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & C0);
    assign S    = p ^ c[3:0];
    assign Cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: word-serial adder pushing one nibble per clock through a single CLA slice
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NIB_W*NIBBLES-1:0]   a,
    input  logic [NIB_W*NIBBLES-1:0]   b,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NIB_W*NIBBLES-1:0]   sum,
    output logic                       cout,
    output logic                       ovf
);
    localparam int W  = NIB_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, b_q, sum_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic             in_ready_q, out_valid_q;
    logic [NIB_W-1:0] nib_s;
    logic             nib_co;
    logic             accept;

    assign accept = in_valid && in_ready_q;

    four_bit_cla u_cla (
        .A    (a_q[NIB_W*idx_q +: NIB_W]),
        .B    (b_q[NIB_W*idx_q +: NIB_W]),
        .C0   (carry_q),
        .S    (nib_s),
        .Cout (nib_co)
    );

    // next-state decode: accept starts a run, last nibble finishes it, consumer drains the result
    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? RUN : IDLE)
                : (state_q == RUN)  ? ((idx_q == LAST) ? DONE : RUN)
                : (out_ready ? IDLE : DONE);
    end

    // state, operand latch, per-nibble sum/carry update and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            if (state_q == IDLE && accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx_q   <= '0;
            end
            if (state_q == RUN) begin
                sum_q[NIB_W*idx_q +: NIB_W] <= nib_s;
                carry_q                     <= nib_co;
                idx_q                       <= idx_q + 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign ovf       = (a_q[W-1] ~^ b_q[W-1]) & (sum_q[W-1] ^ a_q[W-1]);
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of the serial adder against plain arithmetic
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // one full transaction: accept, measure latency, check result, stall in DONE, then drain
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                          input int stall, input bit pulse);
        logic [16:0] e;
        logic        eo;
        int          lat;
        e  = {1'b0, ta} + {1'b0, tbv} + {16'd0, tc};
        eo = (ta[15] == tbv[15]) && (e[15] != ta[15]);
        wait_ready();
        a = ta;
        b = tbv;
        cin = tc;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        chk("in_ready_run", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", lat, 32'd4);
        chk("sum", {16'd0, sum}, {16'd0, e[15:0]});
        chk("cout", {31'd0, cout}, {31'd0, e[16]});
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
        for (int i = 0; i < stall; i++) begin
            if (pulse) begin
                in_valid = 1'b1;
                a = 16'h1111;
                b = 16'h2222;
            end
            step();
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_sum", {15'd0, cout, sum}, {15'd0, e});
            chk("stall_ovf", {31'd0, ovf}, {31'd0, eo});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_ready", {31'd0, in_ready}, 32'd1);
        if (pulse) chk("no_accept_sum", {16'd0, sum}, {16'd0, e[15:0]});
    endtask

    initial begin
        @(negedge clk);
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_outs", {29'd0, cout, ovf, |sum}, 32'd0);
        rst = 1'b0;
        step();
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(16'h5BF5, 16'h3040, 1'b1, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 3, 1'b1);

        wait_ready();
        a = 16'h5BF5;
        b = 16'h3040;
        cin = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        step();
        chk("postrst_ready", {31'd0, in_ready}, 32'd1);
        chk("postrst_outs", {28'd0, out_valid, cout, ovf, |sum}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("postrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'h0003, 16'h0004, 1'b0, 0, 1'b0);

        for (int i = 0; i < 1000; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
